// File: rtl/add_sub_csl_unit.sv
// add_sub_csl_unit: single-cycle ALU slice (ADD, SUB, rotate-left, transfer A)
// with one registered output stage for result and flags.
// Optional build macro ADD_SUB_CSL_NZ_FLAGS_EN adds registered negative and
// zero flag outputs; with it undefined those ports and their logic are absent.
module add_sub_csl_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             valid_out
`ifdef ADD_SUB_CSL_NZ_FLAGS_EN
    ,
    output logic             negative,
    output logic             zero
`endif
);

    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_CSL  = 2'b10,
        OP_XFRA = 2'b11
    } op_e;

    // Arithmetic: SUB is a + ~b + 1, so bit WIDTH of the wide sum is the
    // "no borrow" flag, which is exactly the a >= b carry convention.
    logic [WIDTH:0]     w_add_sum;
    logic [WIDTH:0]     w_sub_sum;
    logic [SHW-1:0]     w_rot_amt;
    logic [2*WIDTH-1:0] w_rot_dbl;
    logic [WIDTH-1:0]   w_rot;

    assign w_add_sum = {1'b0, a} + {1'b0, b};
    assign w_sub_sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

    // Rotate by shifting a doubled copy; the upper half is the rotated word,
    // and an amount of zero falls out naturally with no special case.
    assign w_rot_amt = b[SHW-1:0];
    assign w_rot_dbl = {a, a} << w_rot_amt;
    assign w_rot     = w_rot_dbl[2*WIDTH-1:WIDTH];

    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;

    // Select result and flags for the requested operation.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        w_result   = a;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        unique case (op_e'(op))
            OP_ADD: begin
                w_result   = w_add_sum[WIDTH-1:0];
                w_carry    = w_add_sum[WIDTH];
                w_overflow = (a[WIDTH-1] == b[WIDTH-1]) &&
                             (w_add_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_result   = w_sub_sum[WIDTH-1:0];
                w_carry    = w_sub_sum[WIDTH];
                w_overflow = (a[WIDTH-1] != b[WIDTH-1]) &&
                             (w_sub_sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CSL: begin
                // Last bit rotated out lands in result[0]; no bit moves when n=0.
                w_result = w_rot;
                w_carry  = (w_rot_amt != '0) ? w_rot[0] : 1'b0;
            end
            OP_XFRA: begin
                w_result = a;
            end
            default: begin
                w_result = a;
            end
        endcase
    end

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_overflow;
    logic             r_valid;

    // Output register: reset clears everything, valid loads, idle holds.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignment so all
        // registers update together from pre-edge values.
        if (reset) begin
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= valid_in;
            if (valid_in) begin
                r_result   <= w_result;
                r_carry    <= w_carry;
                r_overflow <= w_overflow;
            end
        end
    end

    assign result    = r_result;
    assign carry     = r_carry;
    assign overflow  = r_overflow;
    assign valid_out = r_valid;

`ifdef ADD_SUB_CSL_NZ_FLAGS_EN
    logic r_negative;
    logic r_zero;

    // Negative/zero flags follow the same load/hold/reset rules as carry.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_negative <= 1'b0;
            r_zero     <= 1'b0;
        end else if (valid_in) begin
            r_negative <= w_result[WIDTH-1];
            r_zero     <= (w_result == '0);
        end
    end

    assign negative = r_negative;
    assign zero     = r_zero;
`endif

endmodule

// File: tb/tb_add_sub_csl_unit.sv
// Scoreboard bench for add_sub_csl_unit: the stimulus process pushes the
// hand-computed response for each issued op; a monitor pops and compares
// whenever valid_out is seen.
module tb_add_sub_csl_unit;

    localparam int WIDTH = 16;

    logic             clock;
    logic             reset;
    logic             valid_in;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             valid_out;
`ifdef ADD_SUB_CSL_NZ_FLAGS_EN
    logic             negative;
    logic             zero;
`endif

    add_sub_csl_unit #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .valid_out (valid_out)
`ifdef ADD_SUB_CSL_NZ_FLAGS_EN
        ,
        .negative  (negative),
        .zero      (zero)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             ov;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cy;
        logic             ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compare each presented result against the oldest expectation.
    always @(negedge clock) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_out", 32'(valid_out), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("carry", 32'(carry), 32'(e.cy));
                check("overflow", 32'(overflow), 32'(e.ov));
`ifdef ADD_SUB_CSL_NZ_FLAGS_EN
                check("negative", 32'(negative), 32'(e.res[WIDTH-1]));
                check("zero", 32'(zero), 32'(e.res == '0));
`endif
            end
        end
    end

    // One clock of stimulus; returns at posedge+1 and checks valid_out there.
    task automatic step(input logic rst, input logic v, input logic [1:0] o,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input exp_t e);
        reset    = rst;
        valid_in = v;
        op       = o;
        a        = av;
        b        = bv;
        if (v && !rst) exp_q.push_back(e);
        @(posedge clock);
        #1;
        check("valid_out", 32'(valid_out), 32'(v && !rst));
    endtask

    // Directed vectors: op, a, b, expected result, carry, overflow.
    vec_t vecs[14];
    initial begin
        vecs[0]  = '{2'b00, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
        vecs[1]  = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0};
        vecs[3]  = '{2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
        vecs[4]  = '{2'b10, 16'h8001, 16'h0001, 16'h0003, 1'b1, 1'b0};
        vecs[5]  = '{2'b10, 16'h1234, 16'h0014, 16'h2341, 1'b1, 1'b0};
        vecs[6]  = '{2'b10, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 16'hABCD, 16'hFFFF, 16'hABCD, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{2'b01, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};
        vecs[11] = '{2'b10, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0};
        vecs[12] = '{2'b10, 16'hF000, 16'h0004, 16'h000F, 1'b1, 1'b0};
        vecs[13] = '{2'b00, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    end

    initial begin
        exp_t none;
        exp_t held;
        none = '0;
        reset = 1'b1; valid_in = 1'b0; op = 2'b00; a = '0; b = '0;

        // Reset state, with a valid op presented that must be discarded.
        step(1'b1, 1'b0, 2'b00, 16'h0000, 16'h0000, none);
        step(1'b1, 1'b1, 2'b00, 16'h1111, 16'h2222, none);
        check("reset_result", 32'(result), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);

        // Back-to-back directed vectors.
        foreach (vecs[i])
            step(1'b0, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b,
                 '{vecs[i].res, vecs[i].cy, vecs[i].ov});

        // Valid ADD followed by three idle cycles: outputs must hold.
        held = '{16'h0300, 1'b0, 1'b0};
        step(1'b0, 1'b1, 2'b00, 16'h0100, 16'h0200, held);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 2'b01, 16'hFFFF, 16'h0001, none);
            check("hold_result", 32'(result), 32'(held.res));
            check("hold_carry", 32'(carry), 32'(held.cy));
            check("hold_overflow", 32'(overflow), 32'(held.ov));
        end

        // Put a nonzero flag state in the register, then reset over a valid op.
        step(1'b0, 1'b1, 2'b01, 16'h8000, 16'h0001, '{16'h7FFF, 1'b1, 1'b1});
        step(1'b1, 1'b1, 2'b00, 16'hFFFF, 16'h0001, none);
        check("rst_prio_result", 32'(result), 32'd0);
        check("rst_prio_carry", 32'(carry), 32'd0);
        check("rst_prio_overflow", 32'(overflow), 32'd0);
`ifdef ADD_SUB_CSL_NZ_FLAGS_EN
        check("rst_prio_negative", 32'(negative), 32'd0);
        check("rst_prio_zero", 32'(zero), 32'd0);
`endif

        // First op after reset release produces a normal result.
        step(1'b0, 1'b1, 2'b01, 16'h0010, 16'h0001, '{16'h000F, 1'b1, 1'b0});
        step(1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000, none);

        // Let the monitor drain, bounded by a cycle budget.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
